// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: sequences the 32-bit control word of the conv core.
// Optional busy-cycle counter output: define CONV_SEQ_CTRL_PERF_EN.
module conv_seq_ctrl #(
  parameter int IFM_WORDS = 4,
  parameter int WHT_WORDS = 2,
  parameter int OUT_WORDS = 7,
  parameter int CHNL_NUM  = 3,
  parameter int CW        = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [CW-1:0] tile_num,
  output logic [31:0]   state,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] tile_idx
`ifdef CONV_SEQ_CTRL_PERF_EN
  ,
  output logic [31:0]   perf_cycles
`endif
);

  localparam int L  = (IFM_WORDS > WHT_WORDS) ? IFM_WORDS : WHT_WORDS;
  localparam int WM = (L > OUT_WORDS) ? L : OUT_WORDS;
  localparam int WW = $clog2(WM + 1);
  localparam int NW = $clog2(CHNL_NUM + 1);

  localparam logic [WW-1:0] L_LAST = WW'(L - 1);
  localparam logic [WW-1:0] O_LAST = WW'(OUT_WORDS - 1);
  localparam logic [WW-1:0] IFM_N  = WW'(IFM_WORDS);
  localparam logic [WW-1:0] WHT_N  = WW'(WHT_WORDS);
  localparam logic [NW-1:0] C_LAST = NW'(CHNL_NUM - 1);

  if (IFM_WORDS < 1 || WHT_WORDS < 1 || OUT_WORDS < 1 || CHNL_NUM < 1) begin : g_bad_cfg
    $error("conv_seq_ctrl: word and channel counts must be >= 1");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_FLUSH, S_PE, S_PA, S_BA,
    S_CA, S_RELU, S_P2SW, S_P2SR, S_DONE
  } st_t;

  st_t           st, st_n;
  logic [WW-1:0] wcnt, wcnt_n;
  logic [NW-1:0] chnl, chnl_n;
  logic [CW-1:0] tile, tile_n;
  logic [CW-1:0] last, last_n;
  logic [31:0]   word_n;

  assign tile_idx = tile;

  // Next-state and loop-counter logic; abort overrides everything.
  always_comb begin
    st_n   = st;
    wcnt_n = wcnt;
    chnl_n = chnl;
    tile_n = tile;
    last_n = last;
    if (abort) begin
      st_n   = S_IDLE;
      wcnt_n = '0;
      chnl_n = '0;
      tile_n = '0;
      last_n = '0;
    end else begin
      unique case (st)
        S_IDLE: if (start) begin
          st_n   = S_LOAD;
          wcnt_n = '0;
          chnl_n = '0;
          tile_n = '0;
          last_n = (tile_num == '0) ? '0 : tile_num - 1'b1;
        end
        S_LOAD: if (wcnt == L_LAST) begin
          wcnt_n = '0;
          st_n   = S_FLUSH;
        end else begin
          wcnt_n = wcnt + 1'b1;
        end
        S_FLUSH: st_n = S_PE;
        S_PE:    st_n = S_PA;
        S_PA:    st_n = S_BA;
        S_BA:    st_n = S_CA;
        S_CA: if (chnl < C_LAST) begin
          chnl_n = chnl + 1'b1;
          st_n   = S_LOAD;
        end else begin
          chnl_n = '0;
          st_n   = S_RELU;
        end
        S_RELU: st_n = S_P2SW;
        S_P2SW: begin
          wcnt_n = '0;
          st_n   = S_P2SR;
        end
        S_P2SR: if (wcnt == O_LAST) begin
          wcnt_n = '0;
          if (tile == last) begin
            st_n = S_DONE;
          end else begin
            tile_n = tile + 1'b1;
            st_n   = S_LOAD;
          end
        end else begin
          wcnt_n = wcnt + 1'b1;
        end
        S_DONE:  st_n = S_IDLE;
        default: st_n = S_IDLE;
      endcase
    end
  end

  // Control word for the upcoming state; shift bits echo last cycle's reads.
  always_comb begin
    word_n = '0;
    unique case (st_n)
      S_LOAD: begin
        word_n[0] = (wcnt_n < IFM_N);
        word_n[1] = (wcnt_n < WHT_N);
        word_n[4] = state[0];
        word_n[5] = state[1];
      end
      S_FLUSH: begin
        word_n[4] = state[0];
        word_n[5] = state[1];
      end
      S_PE:    word_n[3:2] = 2'b11;
      S_PA:    word_n[7:6] = 2'b11;
      S_BA:    word_n[8]   = 1'b1;
      S_CA:    word_n[9]   = 1'b1;
      S_RELU:  word_n[10]  = 1'b1;
      S_P2SW:  word_n[11]  = 1'b1;
      S_P2SR:  word_n[12]  = 1'b1;
      default: word_n      = '0;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st    <= S_IDLE;
      wcnt  <= '0;
      chnl  <= '0;
      tile  <= '0;
      last  <= '0;
      state <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      st    <= st_n;
      wcnt  <= wcnt_n;
      chnl  <= chnl_n;
      tile  <= tile_n;
      last  <= last_n;
      state <= word_n;
      busy  <= (st_n != S_IDLE);
      done  <= (st_n == S_DONE);
    end
  end

`ifdef CONV_SEQ_CTRL_PERF_EN
  // Saturating busy-cycle count, restarted by each accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cycles <= '0;
    end else if (st == S_IDLE && start && !abort) begin
      perf_cycles <= '0;
    end else if (busy && perf_cycles != '1) begin
      perf_cycles <= perf_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// tb_conv_seq_ctrl: random jobs vs. a per-cycle control-word trace model.
// Covers tile counts, tile_num=0, abort, start spam and async reset.
module tb_conv_seq_ctrl;

  localparam int IFM  = 4;
  localparam int WHT  = 2;
  localparam int OUTW = 7;
  localparam int CH   = 3;
  localparam int CW   = 16;
  localparam int L    = (IFM > WHT) ? IFM : WHT;
  localparam int T    = CH * (L + 5) + OUTW + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] tile_num = '0;
  logic [31:0]   state;
  logic          busy;
  logic          done;
  logic [CW-1:0] tile_idx;
`ifdef CONV_SEQ_CTRL_PERF_EN
  logic [31:0]   perf_cycles;
`endif

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] q_word[$];
  int          q_tile[$];

  conv_seq_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .tile_num (tile_num),
    .state    (state),
    .busy     (busy),
    .done     (done),
    .tile_idx (tile_idx)
`ifdef CONV_SEQ_CTRL_PERF_EN
    ,
    .perf_cycles (perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected word and tile index for every cycle of a job of tn tiles.
  task automatic build(input int tn);
    logic [31:0] wd;
    q_word.delete();
    q_tile.delete();
    for (int t = 0; t < tn; t++) begin
      for (int c = 0; c < CH; c++) begin
        for (int w = 0; w < L; w++) begin
          wd = '0;
          wd[0] = (w < IFM);
          wd[1] = (w < WHT);
          wd[4] = (w > 0) && (w - 1 < IFM);
          wd[5] = (w > 0) && (w - 1 < WHT);
          q_word.push_back(wd);
        end
        wd = '0;
        wd[4] = (L - 1 < IFM);
        wd[5] = (L - 1 < WHT);
        q_word.push_back(wd);
        q_word.push_back(32'h0000_000C);
        q_word.push_back(32'h0000_00C0);
        q_word.push_back(32'h0000_0100);
        q_word.push_back(32'h0000_0200);
        for (int i = 0; i < L + 5; i++) q_tile.push_back(t);
      end
      q_word.push_back(32'h0000_0400);
      q_word.push_back(32'h0000_0800);
      for (int i = 0; i < OUTW; i++) q_word.push_back(32'h0000_1000);
      for (int i = 0; i < OUTW + 2; i++) q_tile.push_back(t);
    end
    q_word.push_back(32'h0);
    q_tile.push_back(tn - 1);
  endtask

  task automatic run_job(input int tn_in, input int abort_at, input bit spam);
    int tn;
    int n;
    int ab;
    bit aborted;
    tn = (tn_in == 0) ? 1 : tn_in;
    build(tn);
    n = q_word.size();
    ab = (abort_at >= n) ? 0 : abort_at;
    aborted = 1'b0;
    tile_num = tn_in[CW-1:0];
    start = 1'b1;
    abort = 1'b0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      start = spam ? ($urandom_range(0, 1) == 1) : 1'b0;
      chk("state", state, q_word[k-1]);
      chk("busy", 32'(busy), 32'd1);
      chk("done", 32'(done), 32'(k == n));
      chk("tile_idx", 32'(tile_idx), 32'(q_tile[k-1]));
      if (k == ab) begin
        abort = 1'b1;
        aborted = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    chk("idle_state", state, 32'h0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    if (aborted) chk("abort_tile", 32'(tile_idx), 32'd0);
    repeat (40) begin
      @(posedge clk);
      #1;
      chk("quiet_done", 32'(done), 32'd0);
      chk("quiet_busy", 32'(busy), 32'd0);
    end
`ifdef CONV_SEQ_CTRL_PERF_EN
    if (!aborted) chk("perf", perf_cycles, 32'(n));
`endif
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", state, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_tile", 32'(tile_idx), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_job(1, 0, 1'b0);
    run_job(3, 0, 1'b0);
    run_job(0, 0, 1'b0);
    run_job(2, 15, 1'b0);
    run_job(2, 0, 1'b0);
    run_job(1, 0, 1'b1);
    run_job(2, 0, 1'b1);

    build(3);
    tile_num = 16'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    chk("pre_rst_state", state, q_word[19]);
    #2;
    rst = 1'b1;
    #1;
    chk("async_state", state, 32'h0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_done", 32'(done), 32'd0);
    chk("async_tile", 32'(tile_idx), 32'd0);
`ifdef CONV_SEQ_CTRL_PERF_EN
    chk("async_perf", perf_cycles, 32'h0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_tile", 32'(tile_idx), 32'd0);
    run_job(1, 0, 1'b0);

    repeat (8) begin
      run_job($urandom_range(0, 3),
              ($urandom_range(0, 1) == 1) ? $urandom_range(1, 110) : 0,
              ($urandom_range(0, 1) == 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
